lif_neuron: RTL and testbench

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/lif_pkg.sv | 21 ++
 rtl/lif_weight_sum.sv | 24 ++
 rtl/lif_neuron.sv | 123 ++++++++++++
 tb/tb_lif_neuron.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg: shared constants and FSM state type for the LIF neuron and the
// STDP stage.
//   NUM_PRE   - presynaptic inputs per neuron
//   W_WIDTH   - width of one synaptic weight
//   V_WIDTH   - membrane potential width
//   CNT_WIDTH - refractory counter width
//   SYN_WIDTH - width of the synaptic sum (max NUM_PRE * 15 = 60)
package lif_pkg;

  localparam int NUM_PRE   = 4;
  localparam int W_WIDTH   = 4;
  localparam int V_WIDTH   = 8;
  localparam int CNT_WIDTH = 4;
  localparam int SYN_WIDTH = 6;

  typedef enum logic {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } lif_state_t;

endpackage

// File: rtl/lif_weight_sum.sv
// lif_weight_sum: combinational synaptic sum. Adds the weight of every
// presynaptic input whose spike bit is set.
//   pre_spike [NUM_PRE-1:0]          - one spike bit per presynaptic input
//   weight    [NUM_PRE*W_WIDTH-1:0]  - packed weights, input 0 in the MSBs
//   syn       [SYN_WIDTH-1:0]        - sum of selected weights
module lif_weight_sum
  import lif_pkg::*;
(
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight,
  output logic [SYN_WIDTH-1:0]       syn
);

  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < NUM_PRE; i++) begin
      // input i lives in the i-th nibble counting down from the MSB
      if (pre_spike[i]) begin
        syn = syn + SYN_WIDTH'(weight[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
      end
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with refractory period.
//   clk, rst_n   - clock, synchronous active-low reset
//   en           - advance enable; all state holds when low
//   pre_spike[3:0], weight[15:0] - presynaptic spikes and packed weights
//   post_spike   - registered one-cycle fire pulse
//   membrane[7:0]- membrane potential
//   refractory   - high while in REFRAC
//   spike_count[7:0] - saturating fire count
// Build option: define LIF_LEAK_EN to enable the membrane >> LEAK_SHIFT leak;
// otherwise leak is zero (pure integrate-and-fire) and LEAK_SHIFT is unused.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int THRESHOLD     = 64,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_PRE-1:0]         pre_spike,
  input  logic [NUM_PRE*W_WIDTH-1:0] weight,
  output logic                       post_spike,
  output logic [V_WIDTH-1:0]         membrane,
  output logic                       refractory,
  output logic [7:0]                 spike_count
);

  if (THRESHOLD < 1 || THRESHOLD > 255) begin : g_bad_threshold
    $error("lif_neuron: THRESHOLD out of range 1..255");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT > 7) begin : g_bad_leak_shift
    $error("lif_neuron: LEAK_SHIFT out of range 1..7");
  end
  if (REFRAC_CYCLES < 0 || REFRAC_CYCLES > 15) begin : g_bad_refrac
    $error("lif_neuron: REFRAC_CYCLES out of range 0..15");
  end

  localparam logic [V_WIDTH-1:0]   THR         = V_WIDTH'(THRESHOLD);
  localparam logic [CNT_WIDTH-1:0] REFRAC_LOAD = CNT_WIDTH'(REFRAC_CYCLES);

  lif_state_t           state_q, state_d;
  logic [V_WIDTH-1:0]   membrane_q, membrane_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 post_q, post_d;
  logic [7:0]           count_q, count_d;

  logic [SYN_WIDTH-1:0] syn;
  logic [V_WIDTH-1:0]   leak;
  logic [V_WIDTH:0]     sum_wide;
  logic [V_WIDTH-1:0]   next_v;
  logic                 fire;

  lif_weight_sum u_weight_sum (
    .pre_spike (pre_spike),
    .weight    (weight),
    .syn       (syn)
  );

`ifdef LIF_LEAK_EN
  assign leak = membrane_q >> LEAK_SHIFT;
`else
  assign leak = '0;
`endif

  // leak <= membrane, so the extra bit only ever carries overflow
  assign sum_wide = {1'b0, membrane_q} - {1'b0, leak} + (V_WIDTH+1)'(syn);
  assign next_v   = sum_wide[V_WIDTH] ? '1 : sum_wide[V_WIDTH-1:0];
  assign fire     = (next_v >= THR);

  always_comb begin
    state_d    = state_q;
    membrane_d = membrane_q;
    cnt_d      = cnt_q;
    post_d     = 1'b0;
    count_d    = count_q;
    if (en) begin
      case (state_q)
        INTEG: begin
          if (fire) begin
            membrane_d = '0;
            post_d     = 1'b1;
            if (count_q != '1) count_d = count_q + 8'd1;
            if (REFRAC_CYCLES != 0) begin
              state_d = REFRAC;
              cnt_d   = REFRAC_LOAD;
            end
          end else begin
            membrane_d = next_v;
          end
        end
        REFRAC: begin
          membrane_d = '0;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == CNT_WIDTH'(1)) state_d = INTEG;
        end
        default: state_d = INTEG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INTEG;
      membrane_q <= '0;
      cnt_q      <= '0;
      post_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      membrane_q <= membrane_d;
      cnt_q      <= cnt_d;
      post_q     <= post_d;
      count_q    <= count_d;
    end
  end

  assign post_spike  = post_q;
  assign membrane    = membrane_q;
  assign refractory  = (state_q == REFRAC);
  assign spike_count = count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: directed self-checking bench for lif_neuron.
// Three instances share stimulus: default parameters, REFRAC_CYCLES=0, and
// THRESHOLD=255 with REFRAC_CYCLES=0. Expectations follow LIF_LEAK_EN.
module tb_lif_neuron;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  pre_spike;
  logic [15:0] weight;

  logic       post_a, refr_a, post_b, refr_b, post_c, refr_c;
  logic [7:0] mem_a, cnt_a, mem_b, cnt_b, mem_c, cnt_c;

  int checks = 0;
  int errors = 0;

  lif_neuron #(.THRESHOLD(64), .LEAK_SHIFT(3), .REFRAC_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pre_spike(pre_spike), .weight(weight),
    .post_spike(post_a), .membrane(mem_a), .refractory(refr_a), .spike_count(cnt_a)
  );

  lif_neuron #(.THRESHOLD(64), .LEAK_SHIFT(3), .REFRAC_CYCLES(0)) u_r0 (
    .clk(clk), .rst_n(rst_n), .en(en), .pre_spike(pre_spike), .weight(weight),
    .post_spike(post_b), .membrane(mem_b), .refractory(refr_b), .spike_count(cnt_b)
  );

  lif_neuron #(.THRESHOLD(255), .LEAK_SHIFT(3), .REFRAC_CYCLES(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .pre_spike(pre_spike), .weight(weight),
    .post_spike(post_c), .membrane(mem_c), .refractory(refr_c), .spike_count(cnt_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; pre_spike = 4'h0; weight = 16'h0000;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; pre_spike = 4'hF; weight = 16'hFFFF;
    step();
    step();
    checks++;
    if (mem_a !== 8'd0 || post_a !== 1'b0 || refr_a !== 1'b0 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_a mem=%0d post=%b refr=%b cnt=%0d required 0/0/0/0", mem_a, post_a, refr_a, cnt_a);
    end
    checks++;
    if (mem_b !== 8'd0 || mem_c !== 8'd0 || post_b !== 1'b0 || post_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_bc mem_b=%0d mem_c=%0d post_b=%b post_c=%b required 0", mem_b, mem_c, post_b, post_c);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fire_refrac();
    do_reset();
    weight = 16'hFFFF; pre_spike = 4'hF;
    step();
    checks++;
    if (mem_a !== 8'd60 || post_a !== 1'b0) begin
      errors++;
      $display("FAIL fire_edge1 mem=%0d post=%b required 60/0", mem_a, post_a);
    end
    step();
    checks++;
    if (post_a !== 1'b1 || mem_a !== 8'd0 || cnt_a !== 8'd1 || refr_a !== 1'b1) begin
      errors++;
      $display("FAIL fire_edge2 post=%b mem=%0d cnt=%0d refr=%b required 1/0/1/1", post_a, mem_a, cnt_a, refr_a);
    end
    for (int e = 3; e <= 5; e++) begin
      step();
      checks++;
      if (refr_a !== 1'b1 || mem_a !== 8'd0 || post_a !== 1'b0) begin
        errors++;
        $display("FAIL refrac_hold e%0d refr=%b mem=%0d post=%b required 1/0/0", e, refr_a, mem_a, post_a);
      end
    end
    step();
    checks++;
    if (refr_a !== 1'b0 || mem_a !== 8'd0 || post_a !== 1'b0) begin
      errors++;
      $display("FAIL refrac_exit refr=%b mem=%0d post=%b required 0/0/0", refr_a, mem_a, post_a);
    end
    step();
    checks++;
    if (mem_a !== 8'd60 || post_a !== 1'b0 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL refrac_resume mem=%0d post=%b cnt=%0d required 60/0/1", mem_a, post_a, cnt_a);
    end
  endtask

  task automatic test_weights();
    logic [3:0]  pre_v [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h1};
    logic [15:0] w_v   [6] = '{16'h1248, 16'h1248, 16'h1248, 16'h1248, 16'h1248, 16'h9000};
    logic [7:0]  exp_v [6] = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd5, 8'd9};
    logic [7:0]  exp_l1, exp_l2;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      pre_spike = pre_v[i]; weight = w_v[i];
      step();
      checks++;
      if (mem_a !== exp_v[i]) begin
        errors++;
        $display("FAIL weight_map v%0d mem=%0d required %0d", i, mem_a, exp_v[i]);
      end
    end
`ifdef LIF_LEAK_EN
    exp_l1 = 8'd53; exp_l2 = 8'd47;
`else
    exp_l1 = 8'd60; exp_l2 = 8'd60;
`endif
    do_reset();
    pre_spike = 4'hF; weight = 16'hFFFF;
    step();
    pre_spike = 4'h0;
    step();
    checks++;
    if (mem_a !== exp_l1) begin
      errors++;
      $display("FAIL leak_only1 mem=%0d required %0d", mem_a, exp_l1);
    end
    step();
    checks++;
    if (mem_a !== exp_l2 || post_a !== 1'b0) begin
      errors++;
      $display("FAIL leak_only2 mem=%0d post=%b required %0d/0", mem_a, post_a, exp_l2);
    end
  endtask

  task automatic test_leak();
    int early_fires = 0;
    logic [7:0] exp63, exp64_mem;
    logic       exp64_post;
`ifdef LIF_LEAK_EN
    exp63 = 8'd8; exp64_mem = 8'd8; exp64_post = 1'b0;
`else
    exp63 = 8'd63; exp64_mem = 8'd0; exp64_post = 1'b1;
`endif
    do_reset();
    weight = 16'h1000; pre_spike = 4'h1;
    for (int k = 1; k <= 63; k++) begin
      step();
      if (post_a === 1'b1) early_fires++;
      if (k == 5) begin
        checks++;
        if (mem_a !== 8'd5) begin
          errors++;
          $display("FAIL leak_k5 mem=%0d required 5", mem_a);
        end
      end
    end
    checks++;
    if (early_fires != 0) begin
      errors++;
      $display("FAIL leak_no_early_fire fires=%0d required 0", early_fires);
    end
    checks++;
    if (mem_a !== exp63) begin
      errors++;
      $display("FAIL leak_k63 mem=%0d required %0d", mem_a, exp63);
    end
    step();
    checks++;
    if (mem_a !== exp64_mem || post_a !== exp64_post) begin
      errors++;
      $display("FAIL leak_k64 mem=%0d post=%b required %0d/%b", mem_a, post_a, exp64_mem, exp64_post);
    end
  endtask

  task automatic test_enable();
    do_reset();
    weight = 16'hFFFF; pre_spike = 4'hF;
    step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (mem_a !== 8'd60 || post_a !== 1'b0 || cnt_a !== 8'd0) begin
        errors++;
        $display("FAIL en_hold c%0d mem=%0d post=%b cnt=%0d required 60/0/0", i, mem_a, post_a, cnt_a);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (post_a !== 1'b1 || mem_a !== 8'd0 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL en_resume_fire post=%b mem=%0d cnt=%0d required 1/0/1", post_a, mem_a, cnt_a);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (refr_a !== 1'b1 || post_a !== 1'b0 || cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL en_hold_refrac refr=%b post=%b cnt=%0d required 1/0/1", refr_a, post_a, cnt_a);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (refr_a !== 1'b1) begin
      errors++;
      $display("FAIL en_refrac_count3 refr=%b required 1", refr_a);
    end
    step();
    checks++;
    if (refr_a !== 1'b0) begin
      errors++;
      $display("FAIL en_refrac_count4 refr=%b required 0", refr_a);
    end
  endtask

  task automatic test_reset_mid_refrac();
    do_reset();
    weight = 16'hFFFF; pre_spike = 4'hF;
    step();
    step();
    step();
    checks++;
    if (refr_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_refrac_setup refr=%b required 1", refr_a);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (mem_a !== 8'd0 || post_a !== 1'b0 || refr_a !== 1'b0 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL mid_refrac_reset mem=%0d post=%b refr=%b cnt=%0d required 0/0/0/0", mem_a, post_a, refr_a, cnt_a);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (mem_a !== 8'd60 || refr_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_refrac_resume mem=%0d refr=%b required 60/0", mem_a, refr_a);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (post_a !== 1'b0 || mem_a !== 8'd0 || cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_over_fire post=%b mem=%0d cnt=%0d required 0/0/0", post_a, mem_a, cnt_a);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_refrac_zero();
    int fires = 0;
    int refr_seen = 0;
    int bad_phase = 0;
    do_reset();
    weight = 16'hFFFF; pre_spike = 4'hF;
    for (int e = 1; e <= 600; e++) begin
      step();
      if (post_b === 1'b1) fires++;
      if (refr_b !== 1'b0) refr_seen++;
      if (post_b !== ((e % 2) == 0)) bad_phase++;
      if (e == 20) begin
        checks++;
        if (cnt_b !== 8'd10) begin
          errors++;
          $display("FAIL r0_count_e20 cnt=%0d required 10", cnt_b);
        end
      end
      if (e == 508) begin
        checks++;
        if (cnt_b !== 8'd254) begin
          errors++;
          $display("FAIL r0_count_e508 cnt=%0d required 254", cnt_b);
        end
      end
    end
    checks++;
    if (fires != 300 || bad_phase != 0) begin
      errors++;
      $display("FAIL r0_fire_pattern fires=%0d bad_phase=%0d required 300/0", fires, bad_phase);
    end
    checks++;
    if (refr_seen != 0) begin
      errors++;
      $display("FAIL r0_no_refrac seen=%0d required 0", refr_seen);
    end
    checks++;
    if (cnt_b !== 8'd255) begin
      errors++;
      $display("FAIL r0_count_sat cnt=%0d required 255", cnt_b);
    end
  endtask

  task automatic test_sat_threshold();
    logic [7:0] exp_m [5];
    int fire_edge;
`ifdef LIF_LEAK_EN
    exp_m = '{8'd60, 8'd113, 8'd159, 8'd200, 8'd235};
    fire_edge = 6;
`else
    exp_m = '{8'd60, 8'd120, 8'd180, 8'd240, 8'd0};
    fire_edge = 5;
`endif
    do_reset();
    weight = 16'hFFFF; pre_spike = 4'hF;
    for (int e = 1; e < fire_edge; e++) begin
      step();
      checks++;
      if (mem_c !== exp_m[e-1] || post_c !== 1'b0) begin
        errors++;
        $display("FAIL sat_climb e%0d mem=%0d post=%b required %0d/0", e, mem_c, post_c, exp_m[e-1]);
      end
    end
    step();
    checks++;
    if (post_c !== 1'b1 || mem_c !== 8'd0) begin
      errors++;
      $display("FAIL sat_fire post=%b mem=%0d required 1/0", post_c, mem_c);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pre_spike = 4'h0; weight = 16'h0000;
    test_reset();
    test_fire_refrac();
    test_weights();
    test_leak();
    test_enable();
    test_reset_mid_refrac();
    test_refrac_zero();
    test_sat_threshold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
